approx_mul_error_monitor: RTL and testbench
===========================================

# approx_mul_error_monitor

Exhaustive-sweep error monitor for the approximate 4-input/4-output multiplier netlists (two 2-bit operands packed into `in0..in3`, 4-bit product on `out0..out3`). It drives every input vector into the combinational approximate circuit and consumes its outputs. It compares each output against the exact product and accumulates error statistics: mismatch count, maximum absolute error and summed absolute error. It sits directly around the approximate block as both its stimulus source and its output consumer, and is used in-silicon and in simulation to confirm that a synthesised approximation meets its error threshold `ET`.

## Interface
- `IN_W`, 4: total DUT input bits; must be even. Operand A = `dut_in[IN_W/2-1:0]`, operand B = `dut_in[IN_W-1:IN_W/2]`; `in0` = `dut_in[0]`.
- `OUT_W`, 4: DUT output bits; `out0` = `dut_out[0]`.
- `ET`, 0: error threshold; `pass` requires max absolute error ≤ `ET`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE or DONE.
- `dut_in`  out  `IN_W`  registered stimulus to the approximate circuit.
- `dut_out`  in  `OUT_W`  combinational response of the approximate circuit.
- `busy`  out  1  high during SWEEP and DRAIN.
- `done`  out  1  level; high in DONE until the next accepted `start` or `rst`.
- `err_count`  out  `IN_W+1`  number of vectors with `dut_out` ≠ exact.
- `max_err`  out  `OUT_W`  maximum |approx − exact|.
- `sum_err`  out  `IN_W+OUT_W`  sum of |approx − exact|.
- `pass`  out  1  `done && max_err <= ET`.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE→SWEEP on `start`; DONE→SWEEP on `start`. An accepted start clears `vec`, `err_count`, `max_err`, `sum_err` and the capture-valid bit.
- SWEEP:
  - `dut_in` = `vec`.
  - Each cycle, capture register ← {`dut_out`, exact(`vec`), valid=1}, then `vec`++.
  - When `vec` = 2^IN_W−1 is driven, next state is DRAIN. `vec` does not wrap into a 17th vector.
- DRAIN: one cycle that accumulates the last capture; capture-valid ← 0. Next state is DONE.
- DONE: statistics held stable; `dut_in` holds the last vector.
- Exact product: A×B zero-extended to `OUT_W`. Products exceeding `OUT_W` bits are truncated modulo 2^OUT_W; this cannot occur at default parameters (max 9).
- Accumulate stage, on capture-valid:
  - d = |approx − exact|, computed in `OUT_W+1` bits signed, magnitude stored in `OUT_W` bits.
  - `err_count` += (d≠0).
  - `max_err` = max(`max_err`, d).
  - `sum_err` += d.
  - Counters are sized so they cannot overflow; no saturation is needed.
- `start` in SWEEP/DRAIN is ignored. No queuing.
- `rst` at any time: state IDLE; `dut_in`, all statistics, capture register, `busy`, `done` and `pass` all go to 0 immediately (asynchronously). A sweep interrupted by reset is discarded.

## Timing
- Let `start` be sampled high at the end of cycle T.
  - SWEEP occupies T+1..T+16, driving vectors 0..15.
  - DRAIN is at T+17.
  - `done`=1 from T+18.
  - Total latency = 2^IN_W + 2 cycles.
- `busy`=1 during T+1..T+17.
- Vector k is driven in cycle T+1+k, captured at the end of that cycle, and accumulated at the end of cycle T+2+k.
- `dut_out` must settle within one `clk` period of `dut_in` changing; the DUT path is purely combinational, register-to-register.
- Statistic outputs are registered. Mid-sweep values are partial and only meaningful when `done`=1.
- Reset values: every output is 0.

## Structure
- Shared package `approx_mon_pkg`:
  - FSM state enum.
  - Function `exact_mul(vec)` that splits and multiplies per `IN_W`/`OUT_W`.
  - Localparam `N_VEC = 2**IN_W`.
- Sub-module `approx_err_accum`: capture-valid input, approx and exact operands, async-reset accumulators for count/max/sum, and a synchronous clear input driven by the FSM on accepted start.
- The top level contains the FSM, the vector counter and the capture register.

## Test plan
- Exact-multiplier DUT model, `start` → `done` at T+18, `err_count`=0, `max_err`=0, `sum_err`=0, `pass`=1.
- Stuck-at-zero DUT (`dut_out`=0) → `err_count`=9, `max_err`=9, `sum_err`=36, `pass`=0.
- DUT = exact+1 mod 16 → `err_count`=16, `max_err`=1, `sum_err`=16; `pass`=0 with `ET`=0 and `pass`=1 with `ET`=1.
- Exact DUT except vector 0xF returning 0 (exact 9) → `err_count`=1, `max_err`=9, `sum_err`=9; confirms the last vector is drained.
- Pulse `start` again at T+5 → ignored, `done` still at T+18. Assert `rst` at T+8 → all outputs 0 and IDLE. Restart → clean results identical to the exact-DUT case.
- `start` asserted in DONE → statistics cleared the next cycle, `done` falls, and the second sweep reproduces the first run's values.

Source files
------------

// File: rtl/approx_mon_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor.
package approx_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_IN_W  = 4;
  localparam int unsigned DEF_OUT_W = 4;
  localparam int unsigned N_VEC     = 2 ** DEF_IN_W;

  // Lower half of vec is operand A, upper half is operand B; product truncated to out_w bits.
  function automatic int unsigned exact_mul(input int unsigned vec,
                                            input int unsigned in_w,
                                            input int unsigned out_w);
    int unsigned half;
    int unsigned mask;
    int unsigned a;
    int unsigned b;
    half = in_w / 2;
    mask = (32'd1 << half) - 32'd1;
    a    = vec & mask;
    b    = (vec >> half) & mask;
    return (a * b) & ((32'd1 << out_w) - 32'd1);
  endfunction

endpackage

// File: rtl/approx_err_accum.sv
// Error accumulator: mismatch count, max and summed absolute error of captured samples.
module approx_err_accum
  import approx_mon_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [OUT_W-1:0]      i_approx,
  input  logic [OUT_W-1:0]      i_exact,
  output logic [IN_W:0]         o_err_count,
  output logic [OUT_W-1:0]      o_max_err,
  output logic [IN_W+OUT_W-1:0] o_sum_err
);

  logic signed [OUT_W:0]  w_diff;
  logic [OUT_W-1:0]       w_d;
  logic                   w_nz;
  logic [IN_W:0]          r_count;
  logic [OUT_W-1:0]       r_max;
  logic [IN_W+OUT_W-1:0]  r_sum;

  // Difference in OUT_W+1 signed bits; the magnitude always fits back into OUT_W bits.
  always_comb begin
    w_diff = $signed({1'b0, i_approx}) - $signed({1'b0, i_exact});
    w_d    = w_diff[OUT_W] ? OUT_W'(-w_diff) : OUT_W'(w_diff);
    w_nz   = (w_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_max   <= '0;
      r_sum   <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_max   <= '0;
      r_sum   <= '0;
    end else if (i_valid) begin
      r_count <= r_count + {{IN_W{1'b0}}, w_nz};
      if (w_d > r_max) r_max <= w_d;
      r_sum   <= r_sum + {{IN_W{1'b0}}, w_d};
    end
  end

  assign o_err_count = r_count;
  assign o_max_err   = r_max;
  assign o_sum_err   = r_sum;

endmodule

// File: rtl/approx_mul_error_monitor.sv
// Exhaustive-sweep stimulus source and error monitor wrapped around an approximate multiplier.
module approx_mul_error_monitor
  import approx_mon_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned ET    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic [IN_W:0]         err_count,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W+OUT_W-1:0] sum_err,
  output logic                  pass
);

  localparam logic [IN_W-1:0] LAST_VEC = '1;

  state_t            r_state;
  logic [IN_W-1:0]   r_vec;
  logic              r_busy;
  logic              r_done;
  logic              r_cap_valid;
  logic [OUT_W-1:0]  r_cap_approx;
  logic [OUT_W-1:0]  r_cap_exact;
  logic [OUT_W-1:0]  w_exact;
  logic              w_start_ok;
  logic [OUT_W-1:0]  w_max;

  assign w_exact    = OUT_W'(exact_mul(32'(r_vec), IN_W, OUT_W));
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // r_vec doubles as the registered stimulus; it parks on the last vector rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cap_valid  <= 1'b0;
      r_cap_approx <= '0;
      r_cap_exact  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_cap_valid <= 1'b0;
          if (start) begin
            r_vec   <= '0;
            r_state <= ST_SWEEP;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_SWEEP: begin
          r_cap_valid  <= 1'b1;
          r_cap_approx <= dut_out;
          r_cap_exact  <= w_exact;
          if (r_vec == LAST_VEC) begin
            r_state <= ST_DRAIN;
          end else begin
            r_vec <= r_vec + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_cap_valid <= 1'b0;
          r_state     <= ST_DONE;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_cap_valid <= 1'b0;
        end
      endcase
    end
  end

  approx_err_accum #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_ok),
    .i_valid     (r_cap_valid),
    .i_approx    (r_cap_approx),
    .i_exact     (r_cap_exact),
    .o_err_count (err_count),
    .o_max_err   (w_max),
    .o_sum_err   (sum_err)
  );

  assign dut_in  = r_vec;
  assign busy    = r_busy;
  assign done    = r_done;
  assign max_err = w_max;
  assign pass    = r_done && (32'(w_max) <= ET);

endmodule

// File: tb/tb_approx_mul_error_monitor.sv
// Directed bench: several approximate-multiplier behaviours swept by two monitors (ET=0, ET=1).
module tb_approx_mul_error_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  int         mode;

  logic [3:0] dut_in,    dut_out,    max_err;
  logic [4:0] err_count;
  logic [7:0] sum_err;
  logic       busy, done, pass;

  logic [3:0] dut_in_b,  dut_out_b,  max_err_b;
  logic [4:0] err_count_b;
  logic [7:0] sum_err_b;
  logic       busy_b, done_b, pass_b;

  int n_pass  = 0;
  int n_total = 0;
  int lat;

  always #5 clk = ~clk;

  // 0: exact, 1: stuck at zero, 2: exact+1 mod 16, 3: exact except vector 0xF returns 0
  function automatic logic [3:0] model(input logic [3:0] v, input int m);
    logic [3:0] p;
    p = {2'b00, v[1:0]} * {2'b00, v[3:2]};
    case (m)
      1:       return 4'h0;
      2:       return p + 4'h1;
      3:       return (v == 4'hF) ? 4'h0 : p;
      default: return p;
    endcase
  endfunction

  always_comb dut_out   = model(dut_in, mode);
  always_comb dut_out_b = model(dut_in_b, mode);

  approx_mul_error_monitor #(.IN_W(4), .OUT_W(4), .ET(0)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done),
    .err_count(err_count), .max_err(max_err), .sum_err(sum_err),
    .pass(pass)
  );

  approx_mul_error_monitor #(.IN_W(4), .OUT_W(4), .ET(1)) u_dut_et1 (
    .clk(clk), .rst(rst), .start(start),
    .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b),
    .err_count(err_count_b), .max_err(max_err_b), .sum_err(sum_err_b),
    .pass(pass_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_stats(input string tag, input int ec, input int me, input int se,
                             input int ps, input int ps_b);
    check({tag, "_err_count"}, 32'(err_count), 32'(ec));
    check({tag, "_max_err"},   32'(max_err),   32'(me));
    check({tag, "_sum_err"},   32'(sum_err),   32'(se));
    check({tag, "_pass"},      32'(pass),      32'(ps));
    check({tag, "_pass_et1"},  32'(pass_b),    32'(ps_b));
    check({tag, "_dut_in"},    32'(dut_in),    32'd15);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Pulses start for one cycle (cycle T), then counts cycles until done; optional extra start pulse.
  task automatic run_sweep(input int m, input int extra, output int latency);
    int cyc;
    mode = m;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    check("busy_t1",  32'(busy),      32'd1);
    check("done_t1",  32'(done),      32'd0);
    check("dutin_t1", 32'(dut_in),    32'd0);
    check("clr_t1",   32'(err_count), 32'd0);
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra);
      if (cyc == 17) begin
        check("busy_drain", 32'(busy), 32'd1);
        check("done_drain", 32'(done), 32'd0);
      end
    end
    start   = 1'b0;
    latency = cyc;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    check("rst_dut_in",    32'(dut_in),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_max_err",   32'(max_err),   32'd0);
    check("rst_sum_err",   32'(sum_err),   32'd0);
    check("rst_pass",      32'(pass),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_sweep(0, 0, lat);
    check("exact_latency", 32'(lat), 32'd18);
    check_stats("exact", 0, 0, 0, 1, 1);

    run_sweep(1, 0, lat);
    check("stuck_latency", 32'(lat), 32'd18);
    check_stats("stuck", 9, 9, 36, 0, 0);

    run_sweep(1, 0, lat);
    check("rerun_latency", 32'(lat), 32'd18);
    check_stats("rerun", 9, 9, 36, 0, 0);

    run_sweep(2, 0, lat);
    check("plus1_latency", 32'(lat), 32'd18);
    check_stats("plus1", 16, 1, 16, 0, 1);

    run_sweep(3, 0, lat);
    check("last_latency", 32'(lat), 32'd18);
    check_stats("last", 1, 9, 9, 0, 0);

    run_sweep(1, 5, lat);
    check("ignore_latency", 32'(lat), 32'd18);
    check_stats("ignore", 9, 9, 36, 0, 0);

    // Reset in the middle of a sweep at cycle T+8
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_dut_in", 32'(dut_in), 32'd7);
    check("mid_busy",   32'(busy),   32'd1);
    rst = 1'b1;
    #1;
    check("arst_dut_in",    32'(dut_in),    32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_done",      32'(done),      32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    check("arst_max_err",   32'(max_err),   32'd0);
    check("arst_sum_err",   32'(sum_err),   32'd0);
    check("arst_pass",      32'(pass),      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy",   32'(busy),   32'd0);
    check("idle_done",   32'(done),   32'd0);
    check("idle_dut_in", 32'(dut_in), 32'd0);

    run_sweep(0, 0, lat);
    check("after_rst_latency", 32'(lat), 32'd18);
    check_stats("after_rst", 0, 0, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
